// File: rtl/mxv_sequencer.sv
// -----------------------------------------------------------------------------
// mxv_sequencer
//
// Control sequencer for an N x N matrix-vector multiply (Out = M x V).
// It walks the row and column indices, issues operand addresses and MAC
// strobes to an external single-cycle-latency MAC unit, and hands each
// finished row result to a sink over a valid/ready handshake.
//
// Per row: N RUN cycles (one operand pair each), 1 WAIT cycle (MAC latency),
// then OUT until the sink accepts. Every output is a register. Its value is
// computed from the next state, so the outputs line up with the state the
// FSM is entering.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request an operation (sampled only in IDLE)
//   abort      in   synchronous abort back to IDLE
//   size       in   matrix dimension N, latched on an accepted start
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last row is handed off
//   err_size   out  one-cycle pulse on start with size==0 or size>NMAX
//   mat_addr   out  matrix operand address row*N+col
//   vec_addr   out  vector operand address col
//   mac_en     out  MAC accumulate strobe
//   mac_clr    out  accumulator clear, with the first column of a row
//   mac_last   out  marks the last column of a row
//   out_valid  out  row result available
//   out_ready  in   sink accepts the row result
//   out_row    out  row index of the presented result
// -----------------------------------------------------------------------------
module mxv_sequencer #(
  parameter int NMAX = 8,
  parameter int SW   = $clog2(NMAX + 1),
  parameter int IW   = $clog2(NMAX),
  parameter int AW   = $clog2(NMAX * NMAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] size,
  output logic          busy,
  output logic          done,
  output logic          err_size,
  output logic [AW-1:0] mat_addr,
  output logic [IW-1:0] vec_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_row
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  localparam logic [SW-1:0] NMAX_S = SW'(NMAX);
  localparam logic [SW-1:0] ONE_S  = SW'(1);

  // row*N+col never exceeds NMAX*NMAX-1, so AW bits cannot wrap.
  function automatic logic [AW-1:0] calc_addr(input logic [IW-1:0] r,
                                               input logic [SW-1:0] n,
                                               input logic [IW-1:0] c);
    return AW'(r) * AW'(n) + AW'(c);
  endfunction

  // True when an index is the last one (N-1) for dimension n.
  function automatic logic is_last(input logic [IW-1:0] idx,
                                   input logic [SW-1:0] n);
    return (SW'(idx) == (n - ONE_S));
  endfunction

  state_e        state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [SW-1:0] n_q, n_d;
  logic          err_d;

  logic          busy_q, done_q, err_q;
  logic [AW-1:0] mat_addr_q;
  logic [IW-1:0] vec_addr_q;
  logic          mac_en_q, mac_clr_q, mac_last_q;
  logic          out_valid_q;
  logic [IW-1:0] out_row_q;

  logic          run_d, out_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    n_d     = n_q;
    err_d   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if ((size != '0) && (size <= NMAX_S)) begin
              n_d     = size;
              row_d   = '0;
              col_d   = '0;
              state_d = S_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (is_last(col_q, n_q)) begin
            col_d   = '0;
            state_d = S_WAIT;
          end else begin
            col_d = col_q + IW'(1);
          end
        end
        S_WAIT: state_d = S_OUT;
        S_OUT: begin
          if (out_ready) begin
            if (is_last(row_q, n_q)) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d   = row_q + IW'(1);
              state_d = S_RUN;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    run_d = (state_d == S_RUN);
    out_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mat_addr_q  <= '0;
      vec_addr_q  <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      n_q         <= n_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      err_q       <= err_d;
      mac_en_q    <= run_d;
      mac_clr_q   <= run_d && (col_d == '0);
      mac_last_q  <= run_d && is_last(col_d, n_d);
      mat_addr_q  <= run_d ? calc_addr(row_d, n_d, col_d) : '0;
      vec_addr_q  <= run_d ? col_d : '0;
      out_valid_q <= out_d;
      out_row_q   <= out_d ? row_d : '0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_size  = err_q;
  assign mat_addr  = mat_addr_q;
  assign vec_addr  = vec_addr_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign mac_last  = mac_last_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;

endmodule

// File: tb/tb_mxv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mxv_sequencer
//
// Scoreboard bench for mxv_sequencer (NMAX=8). Stimulus pushes the expected
// output events (MAC operand issue, row handshake, done, err_size) into a
// queue before each operation; a negedge monitor pops and compares one event
// per cycle in which the DUT presents any of them. Timing and stall/abort/reset
// behaviour are checked directly by the stimulus thread at #1 after posedge.
// -----------------------------------------------------------------------------
module tb_mxv_sequencer;

  localparam int NMAX = 8;
  localparam int SW   = 4;
  localparam int IW   = 3;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [SW-1:0] size;
  logic          busy;
  logic          done;
  logic          err_size;
  logic [AW-1:0] mat_addr;
  logic [IW-1:0] vec_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_row;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  mxv_sequencer #(.NMAX(NMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .err_size  (err_size),
    .mat_addr  (mat_addr),
    .vec_addr  (vec_addr),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_last  (mac_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event word: {mac, handshake, done, err, addr[6], vec[3], clr, last, row[3]}
  function automatic logic [31:0] ev(input logic m, input logic h, input logic d,
                                     input logic er, input logic [5:0] a,
                                     input logic [2:0] v, input logic clr,
                                     input logic last, input logic [2:0] r);
    return {14'b0, m, h, d, er, a, v, clr, last, r};
  endfunction

  function automatic logic [31:0] all_outs();
    return {13'b0, busy, done, err_size, mat_addr, vec_addr,
            mac_en, mac_clr, mac_last, out_valid, out_row};
  endfunction

  task automatic push_mac(input int a, input int v, input logic clr, input logic last);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 6'(a), 3'(v), clr, last, 3'd0));
  endtask

  task automatic push_row(input int r);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 3'(r)));
  endtask

  task automatic push_done();
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 3'd0));
  endtask

  task automatic push_err();
    exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 3'd0, 1'b0, 1'b0, 3'd0));
  endtask

  // Full rows 0..nrows-1 of an n x n operation: addr r*n+c, clr on c==0, last on c==n-1.
  task automatic push_rows(input int n, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < n; c++) push_mac(r * n + c, c, (c == 0), (c == n - 1));
      push_row(r);
    end
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  // Monitor: one event per cycle that shows any observable output.
  always @(negedge clk) begin
    logic        hs;
    logic [31:0] obs;
    logic [31:0] e;
    hs = out_valid && out_ready;
    if (reset && (mac_en || hs || done || err_size)) begin
      obs = ev(mac_en, hs, done, err_size,
               mac_en ? mat_addr : 6'd0, mac_en ? vec_addr : 3'd0,
               mac_en & mac_clr, mac_en & mac_last, hs ? out_row : 3'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", obs, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event", obs, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int k;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    size      = '0;
    out_ready = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b1;
    tick();

    // size=3, out_ready high: done 15 cycles after the accepting edge.
    size = 4'd3;
    push_rows(3, 3);
    push_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("n3_first_mac", {30'd0, busy, mac_en}, 32'd3);
    wait_done(40, cyc);
    check("n3_done_latency", cyc, 15);
    tick();
    check("n3_idle_after_done", {30'd0, busy, done}, 32'd0);

    // size=2 with a 4-cycle stall on row 0.
    size      = 4'd2;
    out_ready = 1'b0;
    push_rows(2, 2);
    push_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(10, cyc);
    check("n2_valid_seen", cyc, 3);
    for (int i = 0; i < 4; i++) begin
      check("n2_stall_hold", {27'd0, out_valid, out_row, mac_en}, 32'b10000);
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    check("n2_row1_start", {24'd0, mac_en, mac_clr, mat_addr}, 32'b11000010);
    wait_done(20, cyc);
    check("n2_done_seen", done, 1);
    tick();

    // Illegal sizes: 0 and NMAX+1.
    size = 4'd0;
    push_err();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err0_pulse", {28'd0, err_size, busy, mac_en, done}, 32'b1000);
    tick();
    check("err0_clear", {28'd0, err_size, busy, mac_en, done}, 32'b0000);
    size = 4'd9;
    push_err();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err9_pulse", {28'd0, err_size, busy, mac_en, done}, 32'b1000);
    tick();
    check("err9_clear", {28'd0, err_size, busy, mac_en, done}, 32'b0000);

    // size=1: clr, en and last together.
    size = 4'd1;
    push_mac(0, 0, 1'b1, 1'b1);
    push_row(0);
    push_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("n1_strobes", {23'd0, mac_clr, mac_en, mac_last, mat_addr}, 32'b111000000);
    wait_done(10, cyc);
    check("n1_done_latency", cyc, 3);
    tick();

    // size=4 with start re-pulsed (size=2) during RUN: ignored.
    size = 4'd4;
    push_rows(4, 4);
    push_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    size  = 4'd2;
    tick();
    start = 1'b0;
    size  = 4'd4;
    wait_done(40, cyc);
    check("n4_done_latency", 3 + cyc, 24);
    tick();

    // size=4, abort during row 2 RUN (after address 9 appears).
    push_rows(4, 2);
    push_mac(8, 0, 1'b1, 1'b0);
    push_mac(9, 1, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(mac_en && mat_addr == 6'd9) && k < 30) begin
      tick();
      k++;
    end
    check("abort_addr9_seen", {26'd0, mat_addr}, 32'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outputs", all_outs(), 32'd0);
    repeat (4) tick();
    check("abort_no_done", {31'd0, busy}, 32'd0);

    // abort and start together in IDLE: start discarded.
    size  = 4'd3;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_idle", all_outs(), 32'd0);
    tick();

    // size=3, asynchronous reset during OUT, then a fresh run.
    push_mac(0, 0, 1'b1, 1'b0);
    push_mac(1, 1, 1'b0, 1'b0);
    push_mac(2, 2, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(10, cyc);
    check("rst_valid_seen", cyc, 4);
    reset = 1'b0;
    #1;
    check("rst_async_clear", {30'd0, out_valid, busy}, 32'd0);
    check("rst_all_outputs", all_outs(), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    push_rows(3, 3);
    push_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_restart_row0", {23'd0, mac_clr, mac_en, mac_last, mat_addr}, 32'b110000000);
    wait_done(40, cyc);
    check("rst_restart_done", cyc, 15);
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
